// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: per-channel FSM state encoding.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } btn_state_t;

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-FF synchronizer, debounce/auto-repeat FSM and its counters.
// ev is a combinational strobe that is high on the clock edge that takes a debounce or repeat decision.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned REPEAT_DELAY   = 8,
    parameter int unsigned REPEAT_RATE    = 2,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn,
    output logic       ev,
    output logic       held,
    output btn_state_t state
);

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam bit               REPEAT_EN  = (REPEAT_DELAY != 0);

    logic [1:0]       sync_q;
    logic             btn_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rpt;
    logic             repeated;
    logic [CNT_W-1:0] rpt_last;

    assign btn_s    = sync_q[1];
    assign held     = (state == HELD) || (state == RELEASE_DB);
    // The first repeat waits REPEAT_DELAY ticks, later repeats REPEAT_RATE ticks.
    assign rpt_last = repeated ? RATE_LAST : DELAY_LAST;

    always_comb begin
        ev = 1'b0;
        case (state)
            PRESS_DB: ev = btn_s && tick && (cnt == DB_LAST);
            HELD:     ev = btn_s && tick && REPEAT_EN && (rpt == rpt_last);
            default:  ev = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= 2'b00;
            state    <= IDLE;
            cnt      <= '0;
            rpt      <= '0;
            repeated <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            case (state)
                IDLE: begin
                    if (btn_s && tick) begin
                        state <= PRESS_DB;
                        cnt   <= ONE;
                    end
                end
                PRESS_DB: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (cnt == DB_LAST) begin
                            state    <= HELD;
                            rpt      <= '0;
                            repeated <= 1'b0;
                        end else if (cnt != '1) begin
                            cnt <= cnt + ONE;
                        end
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state <= RELEASE_DB;
                        cnt   <= ONE;
                    end else if (tick && REPEAT_EN) begin
                        if (ev) begin
                            rpt      <= '0;
                            repeated <= 1'b1;
                        end else if (rpt != '1) begin
                            rpt <= rpt + ONE;
                        end
                    end
                end
                RELEASE_DB: begin
                    if (btn_s) begin
                        state    <= HELD;
                        rpt      <= '0;
                        repeated <= 1'b0;
                    end else if (tick) begin
                        if (cnt == DB_LAST) begin
                            state <= IDLE;
                        end else if (cnt != '1) begin
                            cnt <= cnt + ONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Up/Down button conditioner: two independent channels plus the arbitration/output register.
// Events from both channels in the same cycle become a Conflict pulse instead of a request.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned REPEAT_DELAY   = 8,
    parameter int unsigned REPEAT_RATE    = 2,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       Up_Btn,
    input  logic       Down_Btn,
    output logic       Up_Pulse,
    output logic       Down_Pulse,
    output logic       Up_Held,
    output logic       Down_Held,
    output logic       Conflict,
    output btn_state_t Up_State,
    output btn_state_t Down_State
);

    logic up_ev;
    logic dn_ev;

    button_channel #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_RATE   (REPEAT_RATE),
        .CNT_W         (CNT_W)
    ) u_up (
        .clk  (Clock),
        .rst  (Reset),
        .tick (Tick),
        .btn  (Up_Btn),
        .ev   (up_ev),
        .held (Up_Held),
        .state(Up_State)
    );

    button_channel #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_RATE   (REPEAT_RATE),
        .CNT_W         (CNT_W)
    ) u_down (
        .clk  (Clock),
        .rst  (Reset),
        .tick (Tick),
        .btn  (Down_Btn),
        .ev   (dn_ev),
        .held (Down_Held),
        .state(Down_State)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Up_Pulse   <= 1'b0;
            Down_Pulse <= 1'b0;
            Conflict   <= 1'b0;
        end else begin
            Up_Pulse   <= up_ev & ~dn_ev;
            Down_Pulse <= dn_ev & ~up_ev;
            Conflict   <= up_ev & dn_ev;
        end
    end

endmodule
